ps2_key_event_ctrl: RTL and testbench
=====================================

// Module: ps2_key_event_ctrl
// PURPOSE
//  Host-side receive controller for the PS/2 keyboard port, running entirely in the system clock domain.
//  Oversamples kb_clock/kb_data, sequences start/data/parity/stop framing with error checks and a watchdog.
//  Folds E0 (extended) and F0 (break) prefixes into one event per key action.
//  Queues events in a small FIFO behind a valid/ready interface; the ASCII lookup sits downstream of it.
// PARAMETERS
//  SYNC_STAGES     2      flip-flop stages on kb_clock and kb_data (min 2)
//  TIMEOUT_CYCLES  50000  clk cycles without a kb_clock fall before an in-progress frame is abandoned
//  FIFO_DEPTH      4      event FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  kb_clock   in   1  raw PS/2 clock line (asynchronous)
//  kb_data    in   1  raw PS/2 data line (asynchronous)
//  evt_valid  out  1  FIFO head holds an event
//  evt_ready  in   1  consumer accepts head this cycle
//  evt_code   out  8  scan code of head event (make code, prefixes stripped)
//  evt_break  out  1  head event is a key release (F0 seen)
//  evt_ext    out  1  head event is extended (E0 seen)
//  frame_err  out  1  one-cycle pulse: bad start, parity, stop or timeout
//  overflow   out  1  one-cycle pulse: completed event dropped, FIFO full
// BEHAVIOUR
//  Reset: FSM=IDLE, bit counter/watchdog=0, E0/F0 flags clear, FIFO empty, every output 0.
//   A frame in progress is discarded.
//  Sampling: both lines pass through SYNC_STAGES flops. fall = synced kb_clock 1->0, detected in the clk domain.
//   Data is sampled only on the fall cycle.
//  FSM (advances only on fall, except for the watchdog):
//   IDLE:   data=0 -> DATA with bit counter 0; data=1 -> frame_err, stay in IDLE.
//   DATA:   shift data in LSB first; after bit 7 -> PARITY.
//   PARITY: latch parity bit -> STOP.
//   STOP:   good if data=1 AND (8 data bits + parity) has odd ones count; otherwise frame_err.
//     In both cases the FSM returns to IDLE.
//  Watchdog: cleared on every fall and held at 0 in IDLE.
//   In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err.
//   A fall in the same cycle takes precedence and clears the watchdog.
//  Prefix decode on a good byte b:
//   b=E0 -> set ext flag.
//   b=F0 -> set brk flag.
//   Otherwise push {b, brk, ext} and clear both flags.
//   Any frame_err clears both flags.
//  Latency: the push happens in the cycle after the STOP fall cycle; evt_valid rises the next cycle if the FIFO was empty.
//  FIFO: evt_* show the head, registered; pop when evt_valid & evt_ready.
//   Push is accepted when not full, or when full with a pop in the same cycle.
//   A push into a full FIFO with no pop is dropped: overflow pulses for 1 cycle and FIFO contents are unchanged.
//   Pointers wrap modulo FIFO_DEPTH; occupancy count is $clog2(FIFO_DEPTH)+1 bits.
//   Pop on empty is ignored.
//  frame_err and overflow can assert in the same cycle. Both are 0 except in their pulse cycles.
// TESTING
//  Frame 0x1C, odd parity, stop=1 -> one event: code=1C, break=0, ext=0; frame_err stays 0.
//  Frames F0, 1C -> exactly one event: code=1C, break=1, ext=0. Frames E0, F0, 75 -> one event: 75, break=1, ext=1.
//  Frame 0x1C with parity inverted -> frame_err pulses once, no event. A following good 0x23 -> event 23, flags clear.
//  Five data bits, then the clock goes idle -> frame_err at fall+TIMEOUT_CYCLES-1, FSM in IDLE; next frame 0x1C decodes correctly.
//  evt_ready=0, six frames 15,1D,24,2D,2C,35 (DEPTH=4) -> two overflow pulses; then evt_ready=1 pops 15,1D,24,2D in order.
//  reset=1 mid-DATA of 0x1C, then a complete 0x1B frame -> only event 1B; no frame_err.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard receive controller: synchronises the raw PS/2 lines, frames bytes,
// folds E0/F0 prefixes into single key events and queues them behind valid/ready.
module ps2_key_event_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   kb_clk_s;
  logic                   kb_dat_s;
  logic                   fall;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic        err_now;
  logic        byte_good;

  logic        byte_pend;
  logic [7:0]  byte_q;
  logic        ext_q, brk_q;
  logic        push;
  logic [9:0]  push_data;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        full, pop, push_ok, drop;

  assign kb_clk_s = clk_sync[SYNC_STAGES-1];
  assign kb_dat_s = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~kb_clk_s;

  // Synchroniser chains start at the idle-high level so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kb_clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], kb_data};
      clk_prev  <= kb_clk_s;
    end
  end

  // Frame sequencing on each PS/2 clock fall, with the watchdog abandoning stalled frames
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    wdog_d    = '0;
    err_now   = 1'b0;
    byte_good = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!kb_dat_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_now = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {kb_dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = kb_dat_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (kb_dat_s && (^{shift_q, parity_q})) byte_good = 1'b1;
          else err_now = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (wdog_q == WD_MAX) begin
        state_d = IDLE;
        err_now = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // Frame state registers plus the completed-byte handoff to the prefix decoder
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      wdog_q    <= '0;
      frame_err <= 1'b0;
      byte_pend <= 1'b0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      wdog_q    <= wdog_d;
      frame_err <= err_now;
      byte_pend <= byte_good;
      if (byte_good) byte_q <= shift_q;
    end
  end

  assign push      = byte_pend && (byte_q != 8'hE0) && (byte_q != 8'hF0);
  assign push_data = {byte_q, brk_q, ext_q};

  // Prefix flags accumulate E0/F0 until a real scan code or an error consumes them
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (err_now) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_pend) begin
      case (byte_q)
        8'hE0:   ext_q <= 1'b1;
        8'hF0:   brk_q <= 1'b1;
        default: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Event FIFO; a push into a full queue with no simultaneous pop is dropped and flagged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= drop;
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {evt_code, evt_break, evt_ext} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench for ps2_key_event_ctrl: table vectors, multi-cycle corner cases
// and a randomized run compared with a queue-based model of the key event stream.
module tb_ps2_key_event_ctrl;

  localparam int TMO      = 200;
  localparam int DEPTH    = 4;
  localparam int BIT_HALF = 8;

  logic       clk;
  logic       reset;
  logic       kb_clock;
  logic       kb_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       frame_err;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;
  logic [9:0] got_q[$];
  bit rand_en = 1'b0;

  typedef struct {
    logic [2:0][7:0] frames;
    logic [2:0]      bad;
    int              n;
    logic [7:0]      code;
    logic            brk;
    logic            ext;
    int              errs;
  } vec_t;

  vec_t vecs[5];

  ps2_key_event_ctrl #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kb_clock(kb_clock),
    .kb_data(kb_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_break(evt_break),
    .evt_ext(evt_ext),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record pulses and every accepted event away from the active edge
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overflow) ovf_cnt++;
    if (evt_valid && evt_ready) got_q.push_back({evt_code, evt_break, evt_ext});
  end

  // Random back-pressure on the consumer side while enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) evt_ready = 1'($urandom_range(0, 1));
    end
  end

  // Absolute time limit so the run always terminates
  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    kb_data = b;
    tick(BIT_HALF);
    kb_clock = 1'b0;
    tick(BIT_HALF);
    kb_clock = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit((~^b) ^ bad_par);
    sendBit(~bad_stop);
    kb_data = 1'b1;
    tick(20);
  endtask

  function automatic logic [9:0] gotAt(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 10'h3FF;
  endfunction

  initial begin
    int q0, e0, o0, lat;
    logic [9:0] ent;
    logic [9:0] exp_q[$];
    logic [7:0] ovf_codes[4];
    logic m_ext, m_brk;
    int m_err;

    vecs[0] = '{frames: {8'h00, 8'h00, 8'h1C}, bad: 3'b000, n: 1, code: 8'h1C, brk: 1'b0, ext: 1'b0, errs: 0};
    vecs[1] = '{frames: {8'h00, 8'h1C, 8'hF0}, bad: 3'b000, n: 2, code: 8'h1C, brk: 1'b1, ext: 1'b0, errs: 0};
    vecs[2] = '{frames: {8'h75, 8'hF0, 8'hE0}, bad: 3'b000, n: 3, code: 8'h75, brk: 1'b1, ext: 1'b1, errs: 0};
    vecs[3] = '{frames: {8'h00, 8'h23, 8'h1C}, bad: 3'b001, n: 2, code: 8'h23, brk: 1'b0, ext: 1'b0, errs: 1};
    vecs[4] = '{frames: {8'h23, 8'h1C, 8'hE0}, bad: 3'b010, n: 3, code: 8'h23, brk: 1'b0, ext: 1'b0, errs: 1};

    kb_clock  = 1'b1;
    kb_data   = 1'b1;
    evt_ready = 1'b0;
    reset     = 1'b1;
    tick(5);
    checkOutput("reset_evt_valid", int'(evt_valid), 0);
    checkOutput("reset_evt_code", int'(evt_code), 0);
    checkOutput("reset_evt_flags", int'({evt_break, evt_ext}), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick(5);

    $display("[TB] table vectors");
    evt_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      q0 = got_q.size();
      e0 = err_cnt;
      for (int f = 0; f < vecs[v].n; f++) applyStimulus(vecs[v].frames[f], vecs[v].bad[f], 1'b0);
      tick(10);
      ent = gotAt(q0);
      checkOutput($sformatf("vec%0d_events", v), got_q.size() - q0, 1);
      checkOutput($sformatf("vec%0d_code", v), int'(ent[9:2]), int'(vecs[v].code));
      checkOutput($sformatf("vec%0d_break", v), int'(ent[1]), int'(vecs[v].brk));
      checkOutput($sformatf("vec%0d_ext", v), int'(ent[0]), int'(vecs[v].ext));
      checkOutput($sformatf("vec%0d_frame_err", v), err_cnt - e0, vecs[v].errs);
    end

    $display("[TB] watchdog timeout");
    e0 = err_cnt;
    q0 = got_q.size();
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(i[0]);
    kb_data = 1'b1;
    tick(BIT_HALF);
    kb_clock = 1'b0;
    lat = -1;
    for (int c = 1; c <= TMO + 50 && lat < 0; c++) begin
      tick(1);
      if (c == BIT_HALF) kb_clock = 1'b1;
      if (err_cnt != e0) lat = c;
    end
    kb_clock = 1'b1;
    checkOutput("timeout_window", int'(lat >= TMO - 2 && lat <= TMO + 6), 1);
    tick(20);
    checkOutput("timeout_err_count", err_cnt - e0, 1);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    tick(10);
    ent = gotAt(q0);
    checkOutput("after_timeout_events", got_q.size() - q0, 1);
    checkOutput("after_timeout_event", int'(ent), int'({8'h1C, 2'b00}));

    $display("[TB] fifo overflow");
    evt_ready = 1'b0;
    tick(2);
    q0 = got_q.size();
    o0 = ovf_cnt;
    ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    applyStimulus(8'h15, 1'b0, 1'b0);
    applyStimulus(8'h1D, 1'b0, 1'b0);
    applyStimulus(8'h24, 1'b0, 1'b0);
    applyStimulus(8'h2D, 1'b0, 1'b0);
    applyStimulus(8'h2C, 1'b0, 1'b0);
    applyStimulus(8'h35, 1'b0, 1'b0);
    checkOutput("ovf_pulses", ovf_cnt - o0, 2);
    checkOutput("ovf_no_pop", got_q.size() - q0, 0);
    checkOutput("ovf_valid_held", int'(evt_valid), 1);
    evt_ready = 1'b1;
    tick(10);
    checkOutput("ovf_drain_count", got_q.size() - q0, 4);
    for (int i = 0; i < 4; i++) begin
      ent = gotAt(q0 + i);
      checkOutput($sformatf("ovf_drain%0d", i), int'(ent), int'({ovf_codes[i], 2'b00}));
    end
    checkOutput("ovf_empty_after", int'(evt_valid), 0);

    $display("[TB] reset mid-frame");
    q0 = got_q.size();
    e0 = err_cnt;
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    applyStimulus(8'h1B, 1'b0, 1'b0);
    tick(10);
    ent = gotAt(q0);
    checkOutput("midreset_events", got_q.size() - q0, 1);
    checkOutput("midreset_event", int'(ent), int'({8'h1B, 2'b00}));
    checkOutput("midreset_frame_err", err_cnt - e0, 0);

    $display("[TB] randomized frames");
    q0 = got_q.size();
    e0 = err_cnt;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_err = 0;
    rand_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      int sel, kind;
      sel  = $urandom_range(0, 5);
      kind = $urandom_range(0, 9);
      if (sel == 0) b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      applyStimulus(b, kind == 0, kind == 1);
      if (kind <= 1) begin
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        exp_q.push_back({b, m_brk, m_ext});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    rand_en = 1'b0;
    tick(1);
    evt_ready = 1'b1;
    tick(10);
    checkOutput("rand_event_count", got_q.size() - q0, exp_q.size());
    checkOutput("rand_frame_err", err_cnt - e0, m_err);
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput($sformatf("rand_event%0d", i), int'(gotAt(q0 + i)), int'(exp_q[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
